// File: rtl/soc_map_pkg.sv
// Shared SoC memory map: window bases and sizes, default timeout,
// error response word, and the bus controller FSM state encoding.
package soc_map_pkg;

    localparam logic [31:0] DEF_ROM_BASE    = 32'h0000_0000;
    localparam logic [31:0] ROM_SIZE        = 32'h0000_2000;   // 8 KiB
    localparam logic [31:0] DEF_SRAM_BASE   = 32'h2000_0000;
    localparam logic [31:0] SRAM_SIZE       = 32'h0000_2000;   // 8 KiB
    localparam logic [31:0] DEF_PERIPH_BASE = 32'h8000_0000;
    localparam logic [31:0] PERIPH_SIZE     = 32'h0001_0000;   // 64 KiB

    localparam int          DEF_TIMEOUT     = 16;
    localparam logic [31:0] ERR_DATA        = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Power-of-two aligned window match.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        return (addr & ~(size - 32'd1)) == base;
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_addr_decode.sv
// Combinational address decoder: one-hot slave hit {periph, sram, rom}
// plus a miss flag when no window matches.
module addr_decode
    import soc_map_pkg::*;
#(
    parameter logic [31:0] ROM_BASE    = DEF_ROM_BASE,
    parameter logic [31:0] SRAM_BASE   = DEF_SRAM_BASE,
    parameter logic [31:0] PERIPH_BASE = DEF_PERIPH_BASE
) (
    input  logic [31:0] addr,
    output logic [2:0]  hit,
    output logic        miss
);

    // Windows never overlap, so at most one hit bit can be set.
    assign hit[0] = in_window(addr, ROM_BASE,    ROM_SIZE);
    assign hit[1] = in_window(addr, SRAM_BASE,   SRAM_SIZE);
    assign hit[2] = in_window(addr, PERIPH_BASE, PERIPH_SIZE);
    assign miss   = (hit == 3'b000);

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU native-bus to three-slave memory bus controller. One request in
// flight: IDLE decodes, WAIT holds the slave access until ready or
// timeout, RESP returns a one-cycle cpu_ready pulse. Decode misses and
// timeouts return ERR_DATA and set a sticky error flag with the address
// of the first faulting request.
module mem_bus_ctrl
    import soc_map_pkg::*;
#(
    parameter logic [31:0] ROM_BASE    = DEF_ROM_BASE,
    parameter logic [31:0] SRAM_BASE   = DEF_SRAM_BASE,
    parameter logic [31:0] PERIPH_BASE = DEF_PERIPH_BASE,
    parameter int          TIMEOUT     = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_valid,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic        rom_select,
    output logic        sram_select,
    output logic        periph_select,
    output logic [15:0] slv_addr,
    output logic [31:0] slv_wdata,
    output logic [3:0]  slv_wstrb,
    input  logic        rom_ready,
    input  logic        sram_ready,
    input  logic        periph_ready,
    input  logic [31:0] rom_rdata,
    input  logic [31:0] sram_rdata,
    input  logic [31:0] periph_rdata,
    input  logic        err_clr,
    output logic        bus_err,
    output logic [31:0] err_addr
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [2:0]  sel_q, sel_d;          // {periph, sram, rom}
    logic [7:0]  cnt_q, cnt_d;
    logic        ready_d;
    logic [31:0] rdata_d;
    logic        load_req;
    logic        err_evt;
    logic [31:0] err_evt_addr;
    logic [31:0] req_addr;
    logic [2:0]  hit;
    logic        miss;
    logic        sel_ready;
    logic [31:0] sel_rdata;

    addr_decode #(
        .ROM_BASE    (ROM_BASE),
        .SRAM_BASE   (SRAM_BASE),
        .PERIPH_BASE (PERIPH_BASE)
    ) u_decode (
        .addr (cpu_addr),
        .hit  (hit),
        .miss (miss)
    );

    assign rom_select    = sel_q[0];
    assign sram_select   = sel_q[1];
    assign periph_select = sel_q[2];

    // Only the currently selected slave's ready/rdata are observed.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        if (sel_q[0]) begin
            sel_ready = rom_ready;
            sel_rdata = rom_rdata;
        end else if (sel_q[1]) begin
            sel_ready = sram_ready;
            sel_rdata = sram_rdata;
        end else if (sel_q[2]) begin
            sel_ready = periph_ready;
            sel_rdata = periph_rdata;
        end
    end

    // Next-state logic plus next values of the registered outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        ready_d      = 1'b0;
        rdata_d      = cpu_rdata;
        load_req     = 1'b0;
        err_evt      = 1'b0;
        err_evt_addr = req_addr;
        case (state_q)
            ST_IDLE: begin
                if (cpu_valid) begin
                    if (miss) begin
                        state_d      = ST_RESP;
                        ready_d      = 1'b1;
                        rdata_d      = ERR_DATA;
                        err_evt      = 1'b1;
                        err_evt_addr = cpu_addr;
                    end else begin
                        state_d  = ST_WAIT;
                        sel_d    = hit;
                        cnt_d    = '0;
                        load_req = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (sel_ready) begin
                    state_d = ST_RESP;
                    sel_d   = '0;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                    rdata_d = (slv_wstrb != 4'b0000) ? 32'h0 : sel_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RESP;
                    sel_d   = '0;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                    rdata_d = ERR_DATA;
                    err_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from pre-edge values.
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered outputs, request capture and sticky error tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q     <= '0;
            cnt_q     <= '0;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            slv_addr  <= '0;
            slv_wdata <= '0;
            slv_wstrb <= '0;
            req_addr  <= '0;
            bus_err   <= 1'b0;
            err_addr  <= '0;
        end else begin
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            cpu_ready <= ready_d;
            cpu_rdata <= rdata_d;
            if (load_req) begin
                slv_addr  <= cpu_addr[15:0];
                slv_wdata <= cpu_wdata;
                slv_wstrb <= cpu_wstrb;
                req_addr  <= cpu_addr;
            end
            // A new error outranks a concurrent clear.
            if (err_evt) begin
                bus_err <= 1'b1;
            end else if (err_clr) begin
                bus_err <= 1'b0;
            end
            if (err_evt && (!bus_err || err_clr)) begin
                err_addr <= err_evt_addr;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed vector table, hand-written
// error/reset sequences and randomized traffic against a window-range model.
module tb_mem_bus_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_valid = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [3:0]  cpu_wstrb = '0;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        rom_select, sram_select, periph_select;
    logic [15:0] slv_addr;
    logic [31:0] slv_wdata;
    logic [3:0]  slv_wstrb;
    logic        rom_ready, sram_ready, periph_ready;
    logic [31:0] rom_rdata, sram_rdata, periph_rdata;
    logic        err_clr = 1'b0;
    logic        bus_err;
    logic [31:0] err_addr;

    always #5 clk = ~clk;

    mem_bus_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cpu_valid     (cpu_valid),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_wstrb     (cpu_wstrb),
        .cpu_ready     (cpu_ready),
        .cpu_rdata     (cpu_rdata),
        .rom_select    (rom_select),
        .sram_select   (sram_select),
        .periph_select (periph_select),
        .slv_addr      (slv_addr),
        .slv_wdata     (slv_wdata),
        .slv_wstrb     (slv_wstrb),
        .rom_ready     (rom_ready),
        .sram_ready    (sram_ready),
        .periph_ready  (periph_ready),
        .rom_rdata     (rom_rdata),
        .sram_rdata    (sram_rdata),
        .periph_rdata  (periph_rdata),
        .err_clr       (err_clr),
        .bus_err       (bus_err),
        .err_addr      (err_addr)
    );

    // Slave model: a selected slave raises ready once its select has been
    // high for 'lat' earlier cycles; unselected slaves show random noise.
    int          sel_cnt;
    int          rom_lat = 0, sram_lat = 0, periph_lat = 0;
    logic [31:0] rom_data = '0, sram_data = '0, periph_data = '0;
    logic [2:0]  noise = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) sel_cnt <= 0;
        else sel_cnt <= (rom_select | sram_select | periph_select) ? sel_cnt + 1 : 0;
    end

    assign rom_ready    = rom_select    ? (sel_cnt >= rom_lat)    : noise[0];
    assign sram_ready   = sram_select   ? (sel_cnt >= sram_lat)   : noise[1];
    assign periph_ready = periph_select ? (sel_cnt >= periph_lat) : noise[2];
    assign rom_rdata    = rom_data;
    assign sram_rdata   = sram_data;
    assign periph_rdata = periph_data;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Issue one request starting in the current cycle (cycle 0, called at a
    // negedge) and watch until cpu_ready; rdy_cyc stays -1 if it never comes.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                           input logic clr, input logic noisy,
                           output int rdy_cyc, output logic [31:0] rd,
                           output int sel_first, output int sel_cycles, output logic [2:0] sel_seen,
                           output logic [15:0] sa, output logic [31:0] swd, output logic [3:0] sws);
        cpu_valid = 1'b1; cpu_addr = a; cpu_wdata = wd; cpu_wstrb = ws; err_clr = clr;
        rdy_cyc = -1; rd = '0; sel_first = -1; sel_cycles = 0; sel_seen = '0;
        sa = '0; swd = '0; sws = '0;
        for (int c = 1; c <= 100 && rdy_cyc < 0; c++) begin
            @(negedge clk);
            cpu_valid = 1'b0; err_clr = 1'b0;
            if ({periph_select, sram_select, rom_select} != 3'b000) begin
                if (sel_first < 0) sel_first = c;
                sel_cycles++;
                sel_seen = sel_seen | {periph_select, sram_select, rom_select};
                sa = slv_addr; swd = slv_wdata; sws = slv_wstrb;
            end
            if (cpu_ready) begin
                rdy_cyc = c;
                rd = cpu_rdata;
            end
            noise = noisy ? 3'($urandom) : 3'b000;
        end
        noise = 3'b000;
    endtask

    // Reference model: which window an address falls in (-1 = unmapped).
    function automatic int window_of(input logic [31:0] a);
        if (a < 32'h0000_2000) return 0;
        if (a >= 32'h2000_0000 && a < 32'h2000_2000) return 1;
        if (a >= 32'h8000_0000 && a < 32'h8001_0000) return 2;
        return -1;
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lat;
        logic [31:0] sdata;
        int          exp_rdy;
        logic [31:0] exp_rdata;
        logic [2:0]  exp_sel;
        int          exp_selc;
        logic [15:0] exp_saddr;
        logic        exp_err;
        logic [31:0] exp_eaddr;
    } vec_t;

    vec_t vecs[9];

    int          rdy_cyc, sel_first, sel_cycles;
    logic [31:0] rd, swd;
    logic [2:0]  sel_seen;
    logic [15:0] sa;
    logic [3:0]  sws;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h2000_0010, 32'h0,         4'b0000, 1,  32'h1234_5678, 3,  32'h1234_5678, 3'b010, 2,  16'h0010, 1'b0, 32'h0};
        vecs[1] = '{32'h2000_0004, 32'h0000_AB00, 4'b0010, 1,  32'hFFFF_FFFF, 3,  32'h0,         3'b010, 2,  16'h0004, 1'b0, 32'h0};
        vecs[2] = '{32'h0000_1FFC, 32'h0,         4'b0000, 0,  32'hCAFE_0001, 2,  32'hCAFE_0001, 3'b001, 1,  16'h1FFC, 1'b0, 32'h0};
        vecs[3] = '{32'h8000_FFFC, 32'h0,         4'b0000, 3,  32'h5A5A_0003, 5,  32'h5A5A_0003, 3'b100, 4,  16'hFFFC, 1'b0, 32'h0};
        vecs[4] = '{32'h8000_0020, 32'h1111_2222, 4'b1111, 15, 32'h7777_7777, 17, 32'h0,         3'b100, 16, 16'h0020, 1'b0, 32'h0};
        vecs[5] = '{32'h4000_0000, 32'h0,         4'b0000, 0,  32'h0,         1,  32'hDEAD_BEEF, 3'b000, 0,  16'h0,    1'b1, 32'h4000_0000};
        vecs[6] = '{32'h2000_2000, 32'h0,         4'b0000, 0,  32'h0,         1,  32'hDEAD_BEEF, 3'b000, 0,  16'h0,    1'b1, 32'h4000_0000};
        vecs[7] = '{32'h0000_2000, 32'h0,         4'b0100, 0,  32'h0,         1,  32'hDEAD_BEEF, 3'b000, 0,  16'h0,    1'b1, 32'h4000_0000};
        vecs[8] = '{32'h8001_0000, 32'h0,         4'b0000, 0,  32'h0,         1,  32'hDEAD_BEEF, 3'b000, 0,  16'h0,    1'b1, 32'h4000_0000};

        // Reset state, observed both before and between clock edges.
        #2;
        check("rst_sel_async", {29'h0, periph_select, sram_select, rom_select}, 32'h0);
        repeat (3) @(negedge clk);
        check("rst_ready",   {31'h0, cpu_ready}, 32'h0);
        check("rst_rdata",   cpu_rdata, 32'h0);
        check("rst_sel",     {29'h0, periph_select, sram_select, rom_select}, 32'h0);
        check("rst_slv",     {12'h0, slv_wstrb, slv_addr} | slv_wdata, 32'h0);
        check("rst_bus_err", {31'h0, bus_err}, 32'h0);
        check("rst_err_addr", err_addr, 32'h0);

        // Directed vectors; the first one is issued in the first IDLE cycle.
        reset_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rom_lat = vecs[i].lat; sram_lat = vecs[i].lat; periph_lat = vecs[i].lat;
            rom_data = vecs[i].sdata; sram_data = vecs[i].sdata; periph_data = vecs[i].sdata;
            run_txn(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 1'b0, 1'b0,
                    rdy_cyc, rd, sel_first, sel_cycles, sel_seen, sa, swd, sws);
            check($sformatf("v%0d_rdy_cycle", i), rdy_cyc, vecs[i].exp_rdy);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d_sel", i), {29'h0, sel_seen}, {29'h0, vecs[i].exp_sel});
            check($sformatf("v%0d_sel_cycles", i), sel_cycles, vecs[i].exp_selc);
            if (vecs[i].exp_sel != 3'b000) begin
                check($sformatf("v%0d_sel_first", i), sel_first, 1);
                check($sformatf("v%0d_slv_addr", i), {16'h0, sa}, {16'h0, vecs[i].exp_saddr});
                check($sformatf("v%0d_slv_wstrb", i), {28'h0, sws}, {28'h0, vecs[i].wstrb});
                check($sformatf("v%0d_slv_wdata", i), swd, vecs[i].wdata);
            end
            check($sformatf("v%0d_bus_err", i), {31'h0, bus_err}, {31'h0, vecs[i].exp_err});
            check($sformatf("v%0d_err_addr", i), err_addr, vecs[i].exp_eaddr);
            @(negedge clk);
            check($sformatf("v%0d_ready_one_cycle", i), {31'h0, cpu_ready}, 32'h0);
        end

        // err_clr alone clears the sticky flag.
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("clr_bus_err", {31'h0, bus_err}, 32'h0);

        // Peripheral timeout, then a second timeout leaves err_addr alone.
        periph_lat = 1000;
        @(negedge clk);
        run_txn(32'h8000_0040, 32'h0, 4'b0000, 1'b0, 1'b0, rdy_cyc, rd, sel_first, sel_cycles, sel_seen, sa, swd, sws);
        check("to1_sel_cycles", sel_cycles, TO);
        check("to1_rdy_cycle", rdy_cyc, TO + 1);
        check("to1_rdata", rd, 32'hDEAD_BEEF);
        check("to1_bus_err", {31'h0, bus_err}, 32'h1);
        check("to1_err_addr", err_addr, 32'h8000_0040);
        @(negedge clk);
        run_txn(32'h8000_0080, 32'h0, 4'b0001, 1'b0, 1'b0, rdy_cyc, rd, sel_first, sel_cycles, sel_seen, sa, swd, sws);
        check("to2_rdata", rd, 32'hDEAD_BEEF);
        check("to2_err_addr", err_addr, 32'h8000_0040);

        // err_clr concurrent with a miss: the error wins.
        @(negedge clk);
        run_txn(32'h4000_0100, 32'h0, 4'b0000, 1'b1, 1'b0, rdy_cyc, rd, sel_first, sel_cycles, sel_seen, sa, swd, sws);
        check("clrmiss_rdy_cycle", rdy_cyc, 1);
        check("clrmiss_bus_err", {31'h0, bus_err}, 32'h1);
        check("clrmiss_err_addr", err_addr, 32'h4000_0100);

        // Reset in the middle of WAIT abandons the access.
        @(negedge clk);
        cpu_valid = 1'b1; cpu_addr = 32'h8000_0000; cpu_wstrb = 4'b0000;
        @(negedge clk);
        cpu_valid = 1'b0;
        @(negedge clk);
        check("midwait_sel", {31'h0, periph_select}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("midwait_rst_sel", {29'h0, periph_select, sram_select, rom_select}, 32'h0);
        check("midwait_rst_ready", {31'h0, cpu_ready}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        rom_lat = 1; rom_data = 32'h0BAD_F00D;
        run_txn(32'h0000_0100, 32'h0, 4'b0000, 1'b0, 1'b0, rdy_cyc, rd, sel_first, sel_cycles, sel_seen, sa, swd, sws);
        check("postrst_sel_first", sel_first, 1);
        check("postrst_sel", {29'h0, sel_seen}, 32'h1);
        check("postrst_rdy_cycle", rdy_cyc, 3);
        check("postrst_rdata", rd, 32'h0BAD_F00D);
        check("postrst_bus_err", {31'h0, bus_err}, 32'h0);
        @(negedge clk);

        // Randomized traffic with spurious readies on unselected slaves.
        begin
            logic        m_err;
            logic [31:0] m_eaddr;
            m_err = 1'b0;
            m_eaddr = 32'h0;
            for (int n = 0; n < 150; n++) begin
                logic [31:0] a, wd, exp_rd;
                logic [3:0]  ws;
                logic        clr, is_err;
                int          lat, w, exp_rdy, exp_selc;
                logic [2:0]  exp_sel;
                case ($urandom_range(0, 5))
                    0: a = 32'h0000_0000 + ($urandom & 32'h0000_1FFC);
                    1: a = 32'h2000_0000 + ($urandom & 32'h0000_1FFC);
                    2: a = 32'h8000_0000 + ($urandom & 32'h0000_FFFC);
                    3: a = $urandom;
                    4: a = 32'h2000_2000 + ($urandom & 32'h0000_00FC);
                    default: a = 32'h1FFF_FFFC;
                endcase
                wd  = $urandom;
                ws  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
                lat = $urandom_range(0, TO + 2);
                clr = ($urandom_range(0, 7) == 0);
                rom_lat = lat; sram_lat = lat; periph_lat = lat;
                rom_data = $urandom; sram_data = $urandom; periph_data = $urandom;

                w = window_of(a);
                is_err = 1'b0;
                exp_sel = 3'b000;
                if (w < 0) begin
                    exp_rdy = 1; exp_selc = 0; exp_rd = 32'hDEAD_BEEF; is_err = 1'b1;
                end else begin
                    exp_sel = 3'(1 << w);
                    if (lat < TO) begin
                        exp_rdy = lat + 2; exp_selc = lat + 1;
                        exp_rd = (ws != 4'b0000) ? 32'h0 :
                                 (w == 0) ? rom_data : (w == 1) ? sram_data : periph_data;
                    end else begin
                        exp_rdy = TO + 1; exp_selc = TO; exp_rd = 32'hDEAD_BEEF; is_err = 1'b1;
                    end
                end
                if (clr) m_err = 1'b0;
                if (is_err) begin
                    if (!m_err) m_eaddr = a;
                    m_err = 1'b1;
                end

                run_txn(a, wd, ws, clr, 1'b1, rdy_cyc, rd, sel_first, sel_cycles, sel_seen, sa, swd, sws);
                check($sformatf("r%0d_rdy_cycle a=%h", n, a), rdy_cyc, exp_rdy);
                check($sformatf("r%0d_rdata a=%h", n, a), rd, exp_rd);
                check($sformatf("r%0d_sel a=%h", n, a), {29'h0, sel_seen}, {29'h0, exp_sel});
                check($sformatf("r%0d_sel_cycles a=%h", n, a), sel_cycles, exp_selc);
                if (w >= 0) begin
                    check($sformatf("r%0d_slv_addr", n), {16'h0, sa}, {16'h0, a[15:0]});
                    check($sformatf("r%0d_slv_wstrb", n), {28'h0, sws}, {28'h0, ws});
                end
                check($sformatf("r%0d_bus_err", n), {31'h0, bus_err}, {31'h0, m_err});
                check($sformatf("r%0d_err_addr", n), err_addr, m_eaddr);
                @(negedge clk);
                check($sformatf("r%0d_ready_one_cycle", n), {31'h0, cpu_ready}, 32'h0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter ROM_BASE, 32'h0000_0000, base of 8 KiB boot ROM window.
REQ-002 Parameter SRAM_BASE, 32'h2000_0000, base of 8 KiB SRAM window.
REQ-003 Parameter PERIPH_BASE, 32'h8000_0000, base of 64 KiB peripheral window.
REQ-004 Parameter TIMEOUT, 16, max cycles waiting for slave ready (range 2..255).
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 cpu_valid, cpu_addr[31:0], cpu_wdata[31:0], cpu_wstrb[3:0]  in  CPU native-bus request; wstrb 0 = read.
REQ-008 cpu_ready  out  1;  cpu_rdata  out  32  CPU response.
REQ-009 rom_select, sram_select, periph_select  out  1 each  one-hot slave selects.
REQ-010 slv_addr  out  16  request offset within window; slv_wdata  out  32; slv_wstrb  out  4  (shared by all slaves).
REQ-011 rom_ready, sram_ready, periph_ready  in  1 each; rom_rdata, sram_rdata, periph_rdata  in  32 each.
REQ-012 err_clr  in  1  clears error state;  bus_err  out  1  sticky error flag;  err_addr  out  32  address of first faulting request.

Function
REQ-013 FSM states IDLE, WAIT, RESP; one request in flight.
REQ-014 IDLE: on cpu_valid=1 decode cpu_addr; hit -> register slave select, slv_addr=cpu_addr[15:0], slv_wdata, slv_wstrb, go WAIT; miss -> go RESP with error.
REQ-015 Hit = (cpu_addr & ~(window_size-1)) == base; windows never overlap; at most one select high.
REQ-016 WAIT: select and slave outputs held stable; timeout counter increments each cycle from 0.
REQ-017 WAIT: selected slave's ready=1 -> latch its rdata (0 for writes), drop select, go RESP.
REQ-018 Ready inputs of non-selected slaves and any ready outside WAIT are ignored.
REQ-019 WAIT: counter reaches TIMEOUT-1 without ready -> drop select, error response, go RESP.
REQ-020 RESP: cpu_ready=1 for exactly one cycle with cpu_rdata valid; next state IDLE.
REQ-021 Error response: cpu_rdata=32'hDEAD_BEEF; write not performed.
REQ-022 cpu_valid sampled in IDLE only; cpu_valid high in the cycle after RESP starts a new request.
REQ-023 SRAM read latency: cpu_valid seen cycle 0 -> sram_select cycle 1 -> sram_ready cycle 2 -> cpu_ready cycle 3.
REQ-024 Select may remain high one cycle past ready; slaves tolerate duplicate identical access.
REQ-025 On error (miss or timeout), bus_err set next cycle; err_addr loaded only if bus_err was 0.
REQ-026 err_clr=1 clears bus_err; error in same cycle as err_clr wins (bus_err stays 1, err_addr updated).
REQ-027 cpu_ready, all selects, bus_err are registered outputs.

Reset
REQ-028 reset_n low asynchronously forces state IDLE, all selects 0, cpu_ready 0, cpu_rdata 0, slv_* 0, counter 0, bus_err 0, err_addr 0.
REQ-029 Reset mid-WAIT or mid-RESP abandons the transaction; no cpu_ready pulse after reset release.
REQ-030 First request accepted in first IDLE cycle after reset_n rises.

Structure
REQ-031 Window bases, sizes, TIMEOUT default, error data word and FSM state encoding in shared package soc_map_pkg.
REQ-032 Sub-module addr_decode (combinational address -> one-hot slave hit / miss).

Verification
REQ-033 SRAM read: addr 32'h2000_0010, wstrb 0, slave returns 32'h1234_5678 -> sram_select cycle 1, cpu_ready cycle 3 with 32'h1234_5678, slv_addr 16'h0010.
REQ-034 SRAM byte write: addr 32'h2000_0004, wstrb 4'b0010, wdata 32'h0000_AB00 -> slv_wstrb 4'b0010, one cpu_ready pulse, bus_err 0.
REQ-035 Unmapped: addr 32'h4000_0000 -> no select, cpu_ready cycle 1 with 32'hDEAD_BEEF, bus_err 1, err_addr 32'h4000_0000.
REQ-036 Timeout: periph access, periph_ready held 0 -> periph_select drops after 16 cycles, error response, bus_err 1; second error leaves err_addr unchanged.
REQ-037 err_clr pulse with concurrent miss at 32'h4000_0100 -> bus_err stays 1, err_addr 32'h4000_0100.
REQ-038 reset_n low during WAIT -> selects 0 immediately, no cpu_ready; post-reset ROM read completes normally.
